skeleton_pass_scheduler: RTL and testbench
==========================================

// Module: skeleton_pass_scheduler
// PURPOSE
//  Top-level sequencer for the thinning datapath. Owns the shared image RAM port and hands it to one of
//  two users: the external pixel loader, or the centre-mask processing element.
//  Runs the flow load -> alternating subiteration passes A/B -> convergence check.
//  Repeats until a full A+B pair changes no pixel, or until MAX_PASSES pairs have run.
// PARAMETERS
//  N           8   image side length; image is N*N pixels
//  bitSize     6   RAM address MSB index; address width is bitSize+1
//  pixelWidth  8   bits per pixel
//  MAX_PASSES  16  cap on A+B pass pairs before forced completion
// PORTS
//  clk          in   1                            system clock, rising edge
//  rst_n        in   1                            async active-low reset
//  start        in   1                            1-cycle request to begin; honoured only in IDLE or DONE
//  load_valid   in   1                            loader offers load_data
//  load_data    in   pixelWidth                   pixel value to store
//  load_ready   out  1                            scheduler accepts a pixel this cycle
//  mem_we       out  1                            RAM write enable (loader path)
//  mem_addr     out  bitSize+1                    RAM write address (loader path)
//  mem_wdata    out  pixelWidth                   RAM write data (loader path)
//  mem_sel      out  1                            0 = loader owns RAM, 1 = processing element owns RAM
//  pe_start     out  1                            1-cycle pulse that launches one subiteration pass
//  pe_subiter   out  1                            0 = pass A, 1 = pass B; stable while the PE runs
//  pe_done      in   1                            1-cycle pulse: PE finished the current pass
//  pe_changed   in   1                            sampled with pe_done: pass deleted >=1 pixel
//  busy         out  1                            high in every state except IDLE and DONE
//  done         out  1                            skeleton complete; held until next start
//  pass_count   out  $clog2(MAX_PASSES+1)         completed A+B pairs
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; load address=0; pass_count=0; change flag=0.
//    All outputs deasserted: load_ready=mem_we=mem_sel=pe_start=pe_subiter=busy=done=0.
//    mem_addr=0. Completes mid-load or mid-pass without handshake.
//  FSM states: IDLE, LOAD, RUN_A, WAIT_A, RUN_B, WAIT_B, CHECK, DONE.
//  IDLE/DONE + start -> LOAD.
//    Entering LOAD: load address=0, pass_count=0, change flag=0, done drops the same edge.
//  LOAD: load_ready=1, mem_sel=0.
//    mem_we = load_valid & load_ready (combinational); mem_addr = load address; mem_wdata = load_data.
//    Each accepted pixel increments the address.
//    Accepting address N*N-1 -> RUN_A next cycle; the address does not wrap.
//  RUN_A: pe_start=1 for exactly one cycle, pe_subiter=0, mem_sel=1 -> WAIT_A.
//  WAIT_A: waits for pe_done. On pe_done: change flag |= pe_changed, then -> RUN_B.
//  RUN_B / WAIT_B: same as RUN_A / WAIT_A with pe_subiter=1; pe_done -> CHECK.
//  CHECK (1 cycle): pass_count+=1.
//    Then -> DONE if (change flag | pe_changed from this pair) == 0, or if the new pass_count == MAX_PASSES.
//    Otherwise clear change flag -> RUN_A.
//  DONE: done=1, busy=0, mem_sel=0.
//  mem_sel is 1 in RUN_*/WAIT_*/CHECK and 0 in all other states, so the loader and PE never share the
//    port in the same cycle.
//  Ignored inputs:
//    start while busy is ignored.
//    pe_done outside WAIT_A/WAIT_B is ignored.
//    load_valid outside LOAD produces no write.
//    pe_done in the same cycle as pe_start cannot occur; if it does, it is ignored.
//  Latency: minimum start -> done = 1 + N*N + (RUN+WAIT)*2 + CHECK + 1 cycles, with single-cycle PE passes.
//  pass_count saturates at MAX_PASSES and never wraps.
// STRUCTURE
//  Package skel_pkg: typedef enum logic [2:0] sched_state_t; localparam IMG_PIXELS=N*N; localparam ADDR_W=bitSize+1.
//  Sub-module load_addr_gen (clk, rst_n, clr, inc, addr, last): counter that flags last at IMG_PIXELS-1.
//  Sequential logic uses always_ff @(posedge clk or negedge rst_n); output decode is always_comb.
// TESTING
//  1 Reset mid-LOAD after 10 pixels -> all outputs 0 the same cycle.
//    Restart -> mem_addr begins at 0.
//  2 start, 64 pixels with load_valid held high -> mem_we high 64 cycles, addr 0..63.
//    pe_start pulses once with pe_subiter=0 the cycle after addr 63.
//  3 Loader gaps: load_valid toggles 1/0 -> mem_we only on valid cycles; 64 writes total.
//    No address skips.
//  4 PE model reports changed=1,1 then 0,0 -> pass_count=2, done=1, busy=0.
//    Exactly 4 pe_start pulses, alternating subiter 0,1,0,1.
//  5 PE always changed=1, MAX_PASSES=3 -> done after pass_count=3; 6 pe_start pulses.
//  6 start pulse while busy, and spurious pe_done in LOAD -> no state change.
//    Writes unaffected; final result identical to scenario 4.

Source files
------------

// File: rtl/skel_pkg.sv
// Shared types and default geometry for the thinning pass scheduler.
package skel_pkg;

    localparam int IMG_N      = 8;
    localparam int IMG_PIXELS = IMG_N * IMG_N;
    localparam int ADDR_W     = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN_A  = 3'd2,
        WAIT_A = 3'd3,
        RUN_B  = 3'd4,
        WAIT_B = 3'd5,
        CHECK  = 3'd6,
        DONE   = 3'd7
    } sched_state_t;

endpackage

// File: rtl/load_addr_gen.sv
// Loader write-address counter; parks on the last pixel instead of wrapping.
module load_addr_gen #(
    parameter int addrW    = 7,
    parameter int lastAddr = 63
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [addrW-1:0] addr,
    output logic             last
);

    assign last = (addr == addrW'(lastAddr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (clr) begin
            addr <= '0;
        end else if (inc && !last) begin
            addr <= addr + 1'b1;
        end
    end

endmodule

// File: rtl/skeleton_pass_scheduler.sv
// Sequences image load, alternating A/B thinning passes and the convergence check,
// arbitrating the shared image RAM port between the loader and the processing element.
module skeleton_pass_scheduler
    import skel_pkg::*;
#(
    parameter int N          = IMG_N,
    parameter int bitSize    = ADDR_W - 1,
    parameter int pixelWidth = 8,
    parameter int MAX_PASSES = 16,
    localparam int countW    = $clog2(MAX_PASSES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  load_valid,
    input  logic [pixelWidth-1:0] load_data,
    output logic                  load_ready,
    output logic                  mem_we,
    output logic [bitSize:0]      mem_addr,
    output logic [pixelWidth-1:0] mem_wdata,
    output logic                  mem_sel,
    output logic                  pe_start,
    output logic                  pe_subiter,
    input  logic                  pe_done,
    input  logic                  pe_changed,
    output logic                  busy,
    output logic                  done,
    output logic [countW-1:0]     pass_count
);

    sched_state_t      state;
    logic              changeFlag;
    logic              loadClr;
    logic              loadLast;
    logic [countW-1:0] passNext;

    assign mem_we    = load_valid & load_ready;
    assign mem_wdata = load_data;
    assign loadClr   = start && (state == IDLE || state == DONE);
    assign passNext  = (pass_count == countW'(MAX_PASSES)) ? pass_count : pass_count + 1'b1;

    load_addr_gen #(
        .addrW    (bitSize + 1),
        .lastAddr (N * N - 1)
    ) u_addr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (loadClr),
        .inc   (mem_we),
        .addr  (mem_addr),
        .last  (loadLast)
    );

    // Outputs are registered alongside the state so each one changes on the transition edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pass_count <= '0;
            changeFlag <= 1'b0;
            load_ready <= 1'b0;
            mem_sel    <= 1'b0;
            pe_start   <= 1'b0;
            pe_subiter <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            pe_start <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        pass_count <= '0;
                        changeFlag <= 1'b0;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                        load_ready <= 1'b1;
                        mem_sel    <= 1'b0;
                        pe_subiter <= 1'b0;
                    end
                end
                LOAD: begin
                    if (mem_we && loadLast) begin
                        state      <= RUN_A;
                        load_ready <= 1'b0;
                        mem_sel    <= 1'b1;
                        pe_start   <= 1'b1;
                        pe_subiter <= 1'b0;
                    end
                end
                RUN_A: state <= WAIT_A;
                WAIT_A: begin
                    if (pe_done) begin
                        changeFlag <= changeFlag | pe_changed;
                        state      <= RUN_B;
                        pe_start   <= 1'b1;
                        pe_subiter <= 1'b1;
                    end
                end
                RUN_B: state <= WAIT_B;
                WAIT_B: begin
                    // Folding the B result in here lets CHECK look at one flag for the whole pair.
                    if (pe_done) begin
                        changeFlag <= changeFlag | pe_changed;
                        state      <= CHECK;
                    end
                end
                CHECK: begin
                    pass_count <= passNext;
                    if (!changeFlag || passNext == countW'(MAX_PASSES)) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        mem_sel <= 1'b0;
                    end else begin
                        changeFlag <= 1'b0;
                        state      <= RUN_A;
                        pe_start   <= 1'b1;
                        pe_subiter <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_skeleton_pass_scheduler.sv
// Directed and randomized checks of the pass scheduler against a pass-pair reference model.
module tb_skeleton_pass_scheduler;

    localparam int N      = 8;
    localparam int BIT_SZ = 6;
    localparam int PIX_W  = 8;
    localparam int MAXP   = 3;
    localparam int CNT_W  = $clog2(MAXP + 1);
    localparam int PIXELS = N * N;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              load_valid = 1'b0;
    logic [PIX_W-1:0]  load_data = '0;
    logic              load_ready;
    logic              mem_we;
    logic [BIT_SZ:0]   mem_addr;
    logic [PIX_W-1:0]  mem_wdata;
    logic              mem_sel;
    logic              pe_start;
    logic              pe_subiter;
    logic              pe_done = 1'b0;
    logic              pe_changed = 1'b0;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  pass_count;

    int compared = 0;
    int mismatched = 0;

    logic [BIT_SZ:0]  wrAddr[$];
    logic [PIX_W-1:0] wrData[$];
    logic [PIX_W-1:0] expData[$];
    bit               startSub[$];
    bit               changedTab[$];
    int  shareViolations = 0;
    int  doubleStarts = 0;
    int  cycNo = 0;
    int  lastWriteCyc = 0;
    int  firstStartCyc = 0;
    bit  spuriousDone = 1'b0;
    bit  pending = 1'b0;
    bit  prevStart = 1'b0;
    int  waitCnt = 0;

    skeleton_pass_scheduler #(
        .N          (N),
        .bitSize    (BIT_SZ),
        .pixelWidth (PIX_W),
        .MAX_PASSES (MAXP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_sel    (mem_sel),
        .pe_start   (pe_start),
        .pe_subiter (pe_subiter),
        .pe_done    (pe_done),
        .pe_changed (pe_changed),
        .busy       (busy),
        .done       (done),
        .pass_count (pass_count)
    );

    always #5 clk = ~clk;

    // PE model and port monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cycNo++;
        pe_done = 1'b0;
        pe_changed = 1'b0;
        if (!rst_n) begin
            pending = 1'b0;
            prevStart = 1'b0;
        end else begin
            if (pending) begin
                if (waitCnt == 0) begin
                    pe_done = 1'b1;
                    pe_changed = (changedTab.size() > 0) ? changedTab.pop_front() : 1'b0;
                    pending = 1'b0;
                end else begin
                    waitCnt--;
                end
            end
            if (spuriousDone) begin
                pe_done = 1'b1;
                pe_changed = 1'b1;
            end
            if (pe_start) begin
                if (startSub.size() == 0) firstStartCyc = cycNo;
                startSub.push_back(pe_subiter);
                pending = 1'b1;
                waitCnt = $urandom_range(0, 3);
                if (prevStart) doubleStarts++;
            end
            prevStart = pe_start;
            if (mem_we) begin
                wrAddr.push_back(mem_addr);
                wrData.push_back(mem_wdata);
                lastWriteCyc = cycNo;
            end
            if (mem_we && mem_sel) shareViolations++;
        end
    end

    // Pairs run until a pair changes nothing or the pair cap is reached.
    function automatic int expectedPairs(input bit c[$]);
        int pairs = 0;
        for (int p = 0; 2 * p + 1 < c.size(); p++) begin
            pairs++;
            if (!(c[2*p] | c[2*p+1]) || pairs == MAXP) return pairs;
        end
        return pairs;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        compared++;
        assert (obs === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_load_ready"}, 32'(load_ready), 0);
        check({tag, "_mem_we"},     32'(mem_we), 0);
        check({tag, "_mem_sel"},    32'(mem_sel), 0);
        check({tag, "_pe_start"},   32'(pe_start), 0);
        check({tag, "_pe_subiter"}, 32'(pe_subiter), 0);
        check({tag, "_busy"},       32'(busy), 0);
        check({tag, "_done"},       32'(done), 0);
        check({tag, "_mem_addr"},   32'(mem_addr), 0);
        check({tag, "_pass_count"}, 32'(pass_count), 0);
    endtask

    task automatic startRun(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_start_done"},  32'(done), 0);
        check({tag, "_start_busy"},  32'(busy), 1);
        check({tag, "_start_ready"}, 32'(load_ready), 1);
        check({tag, "_start_addr"},  32'(mem_addr), 0);
        check({tag, "_start_count"}, 32'(pass_count), 0);
    endtask

    // mode 0 = valid held, 1 = valid toggles, 2 = random valid
    task automatic feed(input int mode, input int injectAt, input int extraValid);
        int offered = 0;
        int cyc = 0;
        bit v;
        expData.delete();
        while (offered < PIXELS + extraValid && cyc < 1000) begin
            case (mode)
                0: v = 1'b1;
                1: v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            load_valid = v;
            load_data = PIX_W'($urandom);
            start = (cyc == injectAt);
            spuriousDone = (cyc == injectAt);
            if (v) begin
                if (offered < PIXELS) expData.push_back(load_data);
                offered++;
            end
            tick();
            cyc++;
        end
        load_valid = 1'b0;
        start = 1'b0;
        spuriousDone = 1'b0;
    endtask

    task automatic runScenario(input string tag, input int mode, input int injectAt, input int extra);
        int pairs;
        int n = 0;
        int addrBad = 0;
        int dataBad = 0;
        int subBad = 0;
        int lim;
        pairs = expectedPairs(changedTab);
        wrAddr.delete();
        wrData.delete();
        startSub.delete();
        shareViolations = 0;
        doubleStarts = 0;
        startRun(tag);
        feed(mode, injectAt, extra);
        while (done !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        check({tag, "_done_reached"}, 32'(done), 1);
        check({tag, "_busy_at_done"}, 32'(busy), 0);
        check({tag, "_memsel_at_done"}, 32'(mem_sel), 0);
        check({tag, "_pass_count"}, 32'(pass_count), 32'(pairs));
        check({tag, "_write_count"}, 32'(wrAddr.size()), PIXELS);
        lim = (wrAddr.size() < PIXELS) ? wrAddr.size() : PIXELS;
        for (int i = 0; i < lim; i++) begin
            if (wrAddr[i] !== BIT_SZ'(i) + 7'd0) addrBad++;
            if (wrData[i] !== expData[i]) dataBad++;
        end
        check({tag, "_addr_seq_errors"}, 32'(addrBad), 0);
        check({tag, "_data_seq_errors"}, 32'(dataBad), 0);
        check({tag, "_pe_start_count"}, 32'(startSub.size()), 32'(2 * pairs));
        foreach (startSub[i]) if (startSub[i] != bit'(i % 2)) subBad++;
        check({tag, "_subiter_order_errors"}, 32'(subBad), 0);
        check({tag, "_first_start_gap"}, 32'(firstStartCyc - lastWriteCyc), 1);
        check({tag, "_port_share"}, 32'(shareViolations), 0);
        check({tag, "_double_start"}, 32'(doubleStarts), 0);
        repeat (3) tick();
        check({tag, "_done_held"}, 32'(done), 1);
        $display("scenario %s: pairs=%0d writes=%0d pe_starts=%0d", tag, pairs, wrAddr.size(), startSub.size());
    endtask

    initial begin
        // reset state
        #2 rst_n = 1'b0;
        #1 checkAllZero("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // reset in the middle of a load
        changedTab = '{};
        startRun("s1");
        for (int i = 0; i < 10; i++) begin
            load_valid = 1'b1;
            load_data = PIX_W'($urandom);
            tick();
        end
        check("s1_addr_before_reset", 32'(mem_addr), 10);
        #2 rst_n = 1'b0;
        #1 checkAllZero("s1_midload_reset");
        tick();
        load_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        $display("scenario s1: reset after 10 pixels");

        changedTab = '{0, 0};
        runScenario("s2_held_valid", 0, -1, 3);

        changedTab = '{1, 0, 0, 0};
        runScenario("s3_toggle_valid", 1, -1, 0);

        changedTab = '{1, 1, 0, 0};
        runScenario("s4_two_pairs", 0, -1, 0);

        changedTab = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        runScenario("s5_cap", 0, -1, 0);

        changedTab = '{1, 1, 0, 0};
        runScenario("s6_ignored_inputs", 0, 20, 0);

        for (int r = 0; r < 3; r++) begin
            changedTab = '{};
            for (int k = 0; k < 8; k++) changedTab.push_back(1'($urandom_range(0, 1)));
            runScenario($sformatf("rand%0d", r), 2, -1, $urandom_range(0, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
